// File: rtl/pll_lock_supervisor.sv
// Purpose : supervise the PLL reset/lock handshake and hold downstream logic in reset until the PLL lock has been stable.
// Latency : locked seen at edge k -> STABLE at k+2, RUN at k+2+STABLE_CYCLES; lock loss at edge j -> PLL reset at j+2.
// Backpr. : none; this is a free-running supervisor with Moore outputs that are decoded from the state register only.
//
// Ports:
//   i_refclk        reference clock; all flops use its rising edge
//   i_rst           synchronous active-high reset
//   i_pll_locked    PLL locked indication, asynchronous to i_refclk
//   i_clr_stats     synchronous clear of both event counters
//   o_pll_rst       reset to the PLL, high while in PLL_RESET
//   o_sys_rst       reset to downstream logic, high unless in RUN
//   o_ready         high only in RUN
//   o_state         0=PLL_RESET 1=WAIT_LOCK 2=STABLE 3=RUN
//   o_relock_cnt    lock losses seen in RUN, saturating
//   o_timeout_cnt   WAIT_LOCK timeouts, saturating
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 8
) (
    input  logic             i_refclk,
    input  logic             i_rst,
    input  logic             i_pll_locked,
    input  logic             i_clr_stats,
    output logic             o_pll_rst,
    output logic             o_sys_rst,
    output logic             o_ready,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_relock_cnt,
    output logic [CNT_W-1:0] o_timeout_cnt
);

    // One timer is shared by every state, so it is sized for the longest interval.
    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC);

    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TMR_W-1:0]   r_tmr;
    logic [TMR_W-1:0]   w_tmr_nxt;
    logic               w_tmr_inc;
    logic               r_locked_meta;
    logic               r_locked_s;
    logic               w_timeout_inc;
    logic               w_relock_inc;
    logic [CNT_W-1:0]   r_relock_cnt;
    logic [CNT_W-1:0]   r_timeout_cnt;

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_locked_meta <= 1'b0;
            r_locked_s    <= 1'b0;
        end else begin
            r_locked_meta <= i_pll_locked;
            r_locked_s    <= r_locked_meta;
        end
    end

    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_state <= PLL_RESET;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_tmr_inc     = 1'b0;
        w_timeout_inc = 1'b0;
        w_relock_inc  = 1'b0;
        unique case (r_state)
            PLL_RESET: begin
                // Lock status is meaningless while the PLL is held in reset.
                if (r_tmr == RST_LAST) w_state_nxt = WAIT_LOCK;
                else                   w_tmr_inc   = 1'b1;
            end
            WAIT_LOCK: begin
                if (r_locked_s) begin
                    w_state_nxt = STABLE;
                end else if (r_tmr == TIMEOUT_LAST) begin
                    w_state_nxt   = PLL_RESET;
                    w_timeout_inc = 1'b1;
                end else begin
                    w_tmr_inc = 1'b1;
                end
            end
            STABLE: begin
                // Any dropout restarts the whole lock wait with a fresh timeout window.
                if (!r_locked_s)                w_state_nxt = WAIT_LOCK;
                else if (r_tmr == STABLE_LAST)  w_state_nxt = RUN;
                else                            w_tmr_inc   = 1'b1;
            end
            RUN: begin
                if (!r_locked_s) begin
                    w_state_nxt  = PLL_RESET;
                    w_relock_inc = 1'b1;
                end
            end
            default: w_state_nxt = PLL_RESET;
        endcase

        // Every state change starts the next interval from zero.
        if (w_state_nxt != r_state) w_tmr_nxt = '0;
        else if (w_tmr_inc)         w_tmr_nxt = r_tmr + TMR_W'(1);
        else                        w_tmr_nxt = r_tmr;
    end

    // Saturating debug counters; a clear wins over a coincident increment.
    always_ff @(posedge i_refclk) begin
        if (i_rst || i_clr_stats) begin
            r_relock_cnt  <= '0;
            r_timeout_cnt <= '0;
        end else begin
            if (w_relock_inc && !(&r_relock_cnt))
                r_relock_cnt <= r_relock_cnt + CNT_W'(1);
            if (w_timeout_inc && !(&r_timeout_cnt))
                r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
        end
    end

    assign o_pll_rst     = (r_state == PLL_RESET);
    assign o_sys_rst     = (r_state != RUN);
    assign o_ready       = (r_state == RUN);
    assign o_state       = r_state;
    assign o_relock_cnt  = r_relock_cnt;
    assign o_timeout_cnt = r_timeout_cnt;

endmodule
